// File: rtl/parking_payment_if.sv
// Signal bundle between the parking meter payment front end and its surroundings
// (buttons, coin acceptor and the countdown timer feedback).
interface parking_payment_if;
    logic       coin_small;
    logic       coin_large;
    logic       start_btn;
    logic       cancel_btn;
    logic [7:0] time_out;
    logic [7:0] time_in;
    logic       enable;
    logic       expired;
    logic       coin_reject;
    logic [1:0] state_dbg;

    modport slave (
        input  coin_small, coin_large, start_btn, cancel_btn, time_out,
        output time_in, enable, expired, coin_reject, state_dbg
    );

    modport master (
        output coin_small, coin_large, start_btn, cancel_btn, time_out,
        input  time_in, enable, expired, coin_reject, state_dbg
    );
endinterface

// File: rtl/parking_payment_ctrl.sv
// Parking meter payment front end: turns coin/button presses into a saturating credit
// that loads the countdown timer. Define PAY_SYNC_EN to add 2-flop input synchronizers.
module parking_payment_ctrl #(
    parameter int unsigned SMALL_VALUE = 15,
    parameter int unsigned LARGE_VALUE = 60,
    parameter int unsigned MAX_TIME    = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    parking_payment_if.slave pay
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RUN     = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] credit_r, credit_s;
    logic       enable_r, enable_s;
    logic       expired_r, expired_s;
    logic       reject_r, reject_s;
    logic [3:0] raw_s, in_s, in_q_r, edge_s;
    logic       e_small_s, e_large_s, e_start_s, e_cancel_s, coin_edge_s;

    assign raw_s = {pay.cancel_btn, pay.start_btn, pay.coin_large, pay.coin_small};

`ifdef PAY_SYNC_EN
    logic [3:0] sync1_r, sync2_r;

    // Two-flop synchronizer for the raw button/coin levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end
    assign in_s = sync2_r;
`else
    assign in_s = raw_s;
`endif

    assign edge_s      = in_s & ~in_q_r;
    assign e_small_s   = edge_s[0];
    assign e_large_s   = edge_s[1];
    assign e_start_s   = edge_s[2];
    assign e_cancel_s  = edge_s[3];
    assign coin_edge_s = e_small_s | e_large_s;

    function automatic logic [7:0] sat_add(input logic [7:0] base,
                                           input logic       add_small,
                                           input logic       add_large);
        logic [9:0] sum;
        sum = {2'b00, base}
            + (add_small ? 10'(SMALL_VALUE) : 10'd0)
            + (add_large ? 10'(LARGE_VALUE) : 10'd0);
        if (sum > 10'(MAX_TIME)) begin
            sat_add = 8'(MAX_TIME);
        end else begin
            sat_add = sum[7:0];
        end
    endfunction

    // Next-state, next-credit and next-output decode.
    always_comb begin
        state_s  = state_r;
        credit_s = credit_r;
        reject_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (coin_edge_s) begin
                    credit_s = sat_add(credit_r, e_small_s, e_large_s);
                    state_s  = COLLECT;
                end else begin
                    state_s  = IDLE;
                end
            end
            COLLECT: begin
                // Start only once the timer has mirrored the final credit.
                if (e_cancel_s) begin
                    credit_s = 8'd0;
                    state_s  = IDLE;
                end else if (coin_edge_s) begin
                    credit_s = sat_add(credit_r, e_small_s, e_large_s);
                end else if (e_start_s && (pay.time_out == credit_r)) begin
                    state_s  = RUN;
                end else begin
                    state_s  = COLLECT;
                end
            end
            RUN: begin
                reject_s = coin_edge_s;
                if (pay.time_out == 8'd0) begin
                    state_s = EXPIRED;
                end else begin
                    state_s = RUN;
                end
            end
            EXPIRED: begin
                if (coin_edge_s) begin
                    credit_s = sat_add(8'd0, e_small_s, e_large_s);
                    state_s  = COLLECT;
                end else if (e_cancel_s) begin
                    credit_s = 8'd0;
                    state_s  = IDLE;
                end else begin
                    state_s  = EXPIRED;
                end
            end
            default: begin
                credit_s = 8'd0;
                state_s  = IDLE;
            end
        endcase
        enable_s  = (state_s == RUN) || (state_s == EXPIRED);
        expired_s = (state_s == EXPIRED);
    end

    // State, credit, edge history and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            credit_r  <= 8'd0;
            enable_r  <= 1'b0;
            expired_r <= 1'b0;
            reject_r  <= 1'b0;
            in_q_r    <= 4'b0000;
        end else begin
            state_r   <= state_s;
            credit_r  <= credit_s;
            enable_r  <= enable_s;
            expired_r <= expired_s;
            reject_r  <= reject_s;
            in_q_r    <= in_s;
        end
    end

    assign pay.time_in     = credit_r;
    assign pay.enable      = enable_r;
    assign pay.expired     = expired_r;
    assign pay.coin_reject = reject_r;
    assign pay.state_dbg   = state_r;

endmodule

// File: tb/tb_parking_payment_ctrl.sv
// Self-checking bench for parking_payment_ctrl: directed presses, a behavioural credit/mode
// model compared every cycle, a simple countdown timer closing the loop, and literal checks.
module tb_parking_payment_ctrl;

    localparam int SMALL = 15;
    localparam int LARGE = 60;
    localparam int MAXT  = 255;
    localparam int M_IDLE = 0, M_COL = 1, M_RUN = 2, M_EXP = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [7:0] t_out;
    int checks = 0;
    int failures = 0;

    parking_payment_if bus();

    parking_payment_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pay     (bus)
    );

    always #10 clk = ~clk;

    // Countdown timer: loads time_in while disabled, counts down to zero while enabled.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)             t_out <= 8'd0;
        else if (!bus.enable)     t_out <= bus.time_in;
        else if (t_out != 8'd0)   t_out <= t_out - 8'd1;
    end
    assign bus.time_out = t_out;

    // Behavioural model: credit as an integer clipped at MAXT, mode as a plain number.
    int   m_credit, m_mode;
    bit   m_rej;
    logic [3:0] m_prev;
    logic p_small, p_large, p_start, p_cancel;
    int   coin_val;

    assign p_small  = bus.coin_small & ~m_prev[0];
    assign p_large  = bus.coin_large & ~m_prev[1];
    assign p_start  = bus.start_btn  & ~m_prev[2];
    assign p_cancel = bus.cancel_btn & ~m_prev[3];
    assign coin_val = (p_small ? SMALL : 0) + (p_large ? LARGE : 0);

    function automatic int clip(input int v);
        return (v > MAXT) ? MAXT : v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_credit <= 0;
            m_mode   <= M_IDLE;
            m_rej    <= 1'b0;
            m_prev   <= 4'b0000;
        end else begin
            m_prev <= {bus.cancel_btn, bus.start_btn, bus.coin_large, bus.coin_small};
            m_rej  <= (m_mode == M_RUN) && (coin_val > 0);
            if (m_mode == M_IDLE) begin
                if (coin_val > 0) begin m_credit <= clip(coin_val); m_mode <= M_COL; end
            end else if (m_mode == M_COL) begin
                if (p_cancel) begin m_credit <= 0; m_mode <= M_IDLE; end
                else if (coin_val > 0) m_credit <= clip(m_credit + coin_val);
                else if (p_start && (int'(bus.time_out) == m_credit)) m_mode <= M_RUN;
            end else if (m_mode == M_RUN) begin
                if (bus.time_out == 8'd0) m_mode <= M_EXP;
            end else begin
                if (coin_val > 0) begin m_credit <= clip(coin_val); m_mode <= M_COL; end
                else if (p_cancel) begin m_credit <= 0; m_mode <= M_IDLE; end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("model_time_in", int'(bus.time_in), m_credit);
        chk("model_state",   int'(bus.state_dbg), m_mode);
        chk("model_enable",  int'(bus.enable), (m_mode >= M_RUN) ? 1 : 0);
        chk("model_expired", int'(bus.expired), (m_mode == M_EXP) ? 1 : 0);
        chk("model_reject",  int'(bus.coin_reject), int'(m_rej));
    endtask

    task automatic drive(input logic [3:0] v);
        {bus.cancel_btn, bus.start_btn, bus.coin_large, bus.coin_small} = v;
    endtask

    task automatic press(input logic [3:0] v);
        drive(v);
        tick();
        drive(4'b0000);
        tick();
    endtask

    task automatic wait_state(input int want, input int budget);
        int n;
        n = 0;
        while ((int'(bus.state_dbg) != want) && (n < budget)) begin
            tick();
            n++;
        end
        chk("wait_state_bound", int'(bus.state_dbg), want);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_time_in"}, int'(bus.time_in), 0);
        chk({tag, "_enable"},  int'(bus.enable), 0);
        chk({tag, "_expired"}, int'(bus.expired), 0);
        chk({tag, "_reject"},  int'(bus.coin_reject), 0);
        chk({tag, "_state"},   int'(bus.state_dbg), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        drive(4'b0000);
        #5;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Start in IDLE is ignored.
        press(4'b0100);
        chk("idle_start_ignored", int'(bus.state_dbg), 0);

        // One small coin, then large coin held for 10 cycles.
        press(4'b0001);
        chk("small_credit", int'(bus.time_in), 15);
        chk("small_state", int'(bus.state_dbg), 1);
        drive(4'b0010);
        tick();
        chk("large_first", int'(bus.time_in), 75);
        repeat (9) tick();
        drive(4'b0000);
        tick();
        chk("large_held", int'(bus.time_in), 75);

        // Cancel, then five large coins saturating at MAX_TIME.
        press(4'b1000);
        chk("cancel_credit", int'(bus.time_in), 0);
        chk("cancel_state", int'(bus.state_dbg), 0);
        for (int i = 0; i < 5; i++) begin
            int exp_c;
            press(4'b0010);
            exp_c = (i == 4) ? 255 : 60 * (i + 1);
            chk("five_large", int'(bus.time_in), exp_c);
        end

        // Start together with a coin is ignored; credit stays saturated.
        press(4'b0101);
        chk("start_with_coin_state", int'(bus.state_dbg), 1);
        chk("start_with_coin_credit", int'(bus.time_in), 255);
        press(4'b1000);

        // Credit 15, start once the timer is loaded, then a coin in RUN is rejected.
        press(4'b0001);
        tick();
        press(4'b0100);
        chk("run_enable", int'(bus.enable), 1);
        chk("run_state", int'(bus.state_dbg), 2);
        drive(4'b0001);
        tick();
        chk("reject_pulse", int'(bus.coin_reject), 1);
        chk("reject_credit", int'(bus.time_in), 15);
        drive(4'b0000);
        tick();
        chk("reject_one_cycle", int'(bus.coin_reject), 0);
        wait_state(3, 40);
        chk("expired_flag", int'(bus.expired), 1);
        chk("expired_enable", int'(bus.enable), 1);

        // Coin in EXPIRED discards the old credit.
        press(4'b0010);
        chk("exp_coin_credit", int'(bus.time_in), 60);
        chk("exp_coin_state", int'(bus.state_dbg), 1);
        chk("exp_coin_enable", int'(bus.enable), 0);
        chk("exp_coin_expired", int'(bus.expired), 0);

        // Cancel beats a coin in the same cycle.
        drive(4'b1010);
        tick();
        chk("cancel_coin_credit", int'(bus.time_in), 0);
        chk("cancel_coin_state", int'(bus.state_dbg), 0);
        chk("cancel_coin_reject", int'(bus.coin_reject), 0);
        drive(4'b0000);
        tick();

        // Reset mid-RUN with credit 60, then restart from zero.
        press(4'b0010);
        tick();
        press(4'b0100);
        chk("run60_state", int'(bus.state_dbg), 2);
        chk("run60_credit", int'(bus.time_in), 60);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        chk("after_reset_state", int'(bus.state_dbg), 0);
        press(4'b0001);
        chk("restart_credit", int'(bus.time_in), 15);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
